// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial add/subtract datapath: FSM state encoding and default width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_sub.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module bit_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial a - b, LSB first: operands latched on en in IDLE, WIDTH shift cycles, one DONE cycle.
// done/busy decode registered state only; en is ignored outside IDLE.
module sub_serial
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             w_diff;
    logic             w_bout;
    logic             w_last;

    bit_sub u_bit_sub (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_diff),
        .bout (w_bout)
    );

    assign w_last = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = SUB;
            SUB:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_out        <= '0;
            r_count      <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_out        <= '0;
                        r_count      <= '0;
                        r_borrow     <= 1'b0;
                        r_borrow_out <= 1'b0;
                    end
                end
                SUB: begin
                    // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    r_out    <= {w_diff, r_out[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_borrow_out <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out        = r_out;
    assign borrow_out = r_borrow_out;
    assign done       = (r_state == DONE);
    assign busy       = (r_state == SUB) || (r_state == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH=8): driver queues expected results, negedge monitor checks them.
module tb_sub_serial;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       borrow_out;
    logic       done;
    logic       busy;

    typedef struct packed {
        logic [7:0] diff;
        logic       bo;
    } exp_t;

    exp_t q[$];
    int   n_checks;
    int   n_errors;
    int   n_ops;
    int   done_cnt;
    int   lat;
    logic prev_busy;
    logic prev_done;

    sub_serial #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .b          (b),
        .out        (out),
        .borrow_out (borrow_out),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: start detection, latency, pulse width and result comparison.
    always @(negedge clk) begin
        if (rst) begin
            lat       = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy) lat = prev_busy ? lat + 1 : 1;
            if (done) begin
                exp_t e;
                done_cnt++;
                chk("done_latency", lat, 9);
                chk("done_pulse_width", {31'd0, prev_done}, 0);
                chk("busy_during_done", {31'd0, busy}, 1);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out", {24'd0, out}, {24'd0, e.diff});
                    chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic bo);
        exp_t e;
        e.diff = d;
        e.bo   = bo;
        q.push_back(e);
        n_ops++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] d, input logic bo);
        wait_idle();
        a  = av;
        b  = bv;
        en = 1'b1;
        push_exp(d, bo);
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = 8'($urandom);
        b  = 8'($urandom);
        @(negedge clk);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [7:0] ra;
        logic [7:0] rb;
        n_checks = 0;
        n_errors = 0;
        n_ops    = 0;
        done_cnt = 0;
        rst = 1'b1;
        en  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        #3;
        chk("rst_out", {24'd0, out}, 0);
        chk("rst_borrow", {31'd0, borrow_out}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 0);

        // Directed vectors (hand-computed).
        do_op(8'h05, 8'h03, 8'h02, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1);
        do_op(8'h00, 8'h01, 8'hFF, 1'b1);
        do_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        do_op(8'h80, 8'h7F, 8'h01, 1'b0);

        // en toggling and operand changes during SUB must not disturb or restart.
        wait_idle();
        a = 8'h10; b = 8'h01; en = 1'b1;
        push_exp(8'h0F, 1'b0);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            en = ~en;
            a  = 8'($urandom);
            b  = 8'($urandom);
        end
        en = 1'b0;
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            chk("no_restart", {31'd0, busy}, 0);
        end

        // en held high: second op loads operands present in the IDLE cycle after DONE.
        wait_idle();
        a = 8'h20; b = 8'h05; en = 1'b1;
        push_exp(8'h1B, 1'b0);
        push_exp(8'hFE, 1'b1);
        @(posedge clk);
        #1;
        a = 8'h07; b = 8'h09;
        @(negedge clk);
        wait_idle();
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = 8'h55; b = 8'h11;
        @(negedge clk);
        chk("held_restart_busy", {31'd0, busy}, 1);
        wait_idle();

        // Reset during SUB cycle 4 discards the operation.
        wait_idle();
        d0 = done_cnt;
        a = 8'hA5; b = 8'h3C; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out", {24'd0, out}, 0);
        chk("abort_borrow", {31'd0, borrow_out}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        do_op(8'hA5, 8'h3C, 8'h69, 1'b0);

        // Reference-model sweep.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, ra - rb, (ra < rb));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_count", done_cnt, n_ops);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
